// File: rtl/wts_pkg.sv
// Shared types and constants for the wave table RAM arbiter.
// The RAM holds WTS_CH_NUM waveforms of WTS_WAVE_LEN bytes each.
package wts_pkg;

    localparam int WTS_WAVE_LEN  = 32;
    localparam int WTS_CH_NUM    = 12;
    localparam int WTS_RAM_DEPTH = WTS_WAVE_LEN * WTS_CH_NUM;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        DONE
    } wts_arb_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_SND
    } wts_grant_t;

endpackage

// File: rtl/wts_ram_arbiter_if.sv
// CPU port, sound fetch port and wave table RAM pins of the arbiter.
// master = requesters plus the RAM; slave = the arbiter itself.
interface wts_ram_arbiter_if;

    logic       cpu_req;
    logic       cpu_wr;
    logic [8:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_ack;
    logic [7:0] cpu_q;

    logic       snd_req;
    logic [3:0] snd_ch;
    logic [4:0] snd_idx;
    logic       snd_ack;
    logic [7:0] snd_q;

    logic       sram_we;
    logic [8:0] sram_a;
    logic [7:0] sram_d;
    logic [7:0] sram_q;

    modport master (
        output cpu_req, cpu_wr, cpu_a, cpu_d,
        input  cpu_ack, cpu_q,
        output snd_req, snd_ch, snd_idx,
        input  snd_ack, snd_q,
        input  sram_we, sram_a, sram_d,
        output sram_q
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_a, cpu_d,
        output cpu_ack, cpu_q,
        input  snd_req, snd_ch, snd_idx,
        output snd_ack, snd_q,
        output sram_we, sram_a, sram_d,
        input  sram_q
    );

endinterface

// File: rtl/wts_rr_grant.sv
// Two-way picker between CPU and sound requests, combinational, one-hot grant {snd, cpu}.
// On a tie: alternate against last_grant, or sound always wins when ROUND_ROBIN is 0.
module wts_rr_grant
    import wts_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       cpu_req,
    input  logic       snd_req,
    input  wts_grant_t last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (cpu_req && snd_req) begin
            if (ROUND_ROBIN && (last_grant == GNT_SND)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (cpu_req) begin
            grant = 2'b01;
        end else if (snd_req) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/wts_ram_arbiter.sv
// Shares the single-port wave table RAM between CPU and sound fetch; ack 3 cycles after the grant edge.
// One access in flight; requesters hold req until ack, and other requests wait for IDLE.
module wts_ram_arbiter
    import wts_pkg::*;
#(
    parameter int RAM_DEPTH   = WTS_RAM_DEPTH,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic clk,
    input  logic nreset,
    wts_ram_arbiter_if.slave bus
);

    localparam logic [9:0] DEPTH_W = 10'(RAM_DEPTH);

    wts_arb_state_t state_q;
    wts_arb_state_t state_d;
    wts_grant_t     last_grant_q;
    logic [1:0]     grant;
    logic           sel_snd_q;
    logic           wr_q;
    logic           in_range_q;
    logic [8:0]     snd_addr;
    logic           cpu_in_range;
    logic           snd_in_range;

    assign snd_addr     = {bus.snd_ch, bus.snd_idx};
    assign cpu_in_range = {1'b0, bus.cpu_a} < DEPTH_W;
    assign snd_in_range = {1'b0, snd_addr} < DEPTH_W;

    wts_rr_grant #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_grant (
        .cpu_req    (bus.cpu_req),
        .snd_req    (bus.snd_req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant != 2'b00) state_d = ADDR;
            ADDR:    state_d = WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sram_a/sram_d are the latched request; they are only reloaded on a grant.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            last_grant_q <= GNT_CPU;
            sel_snd_q    <= 1'b0;
            wr_q         <= 1'b0;
            in_range_q   <= 1'b0;
            bus.sram_we  <= 1'b0;
            bus.sram_a   <= '0;
            bus.sram_d   <= '0;
            bus.cpu_ack  <= 1'b0;
            bus.cpu_q    <= '0;
            bus.snd_ack  <= 1'b0;
            bus.snd_q    <= '0;
        end else begin
            bus.sram_we <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.snd_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant[0]) begin
                        last_grant_q <= GNT_CPU;
                        sel_snd_q    <= 1'b0;
                        wr_q         <= bus.cpu_wr;
                        in_range_q   <= cpu_in_range;
                        bus.sram_a   <= bus.cpu_a;
                        bus.sram_d   <= bus.cpu_d;
                        bus.sram_we  <= bus.cpu_wr && cpu_in_range;
                    end else if (grant[1]) begin
                        last_grant_q <= GNT_SND;
                        sel_snd_q    <= 1'b1;
                        wr_q         <= 1'b0;
                        in_range_q   <= snd_in_range;
                        bus.sram_a   <= snd_addr;
                    end
                end
                WAIT: begin
                    if (sel_snd_q) begin
                        bus.snd_q   <= in_range_q ? bus.sram_q : 8'h00;
                        bus.snd_ack <= 1'b1;
                    end else begin
                        if (!wr_q) begin
                            bus.cpu_q <= in_range_q ? bus.sram_q : 8'hFF;
                        end
                        bus.cpu_ack <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wts_ram_arbiter.sv
// Bench for wts_ram_arbiter: RAM model, scoreboard on the ack pulses, vector table and corner sequences.
module tb_wts_ram_arbiter;
    import wts_pkg::*;

    typedef struct {
        bit         is_snd;
        bit         wr;
        logic [8:0] a;
        logic [3:0] ch;
        logic [4:0] idx;
        logic [7:0] d;
        logic [8:0] exp_a;
        bit         exp_we;
        logic [7:0] exp_q;
    } vec_t;

    logic clk;
    logic nreset;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   cpu_ack_cnt = 0;
    logic [7:0] last_cpu_q = 8'h00;
    logic [7:0] cpu_exp_q[$];
    logic [7:0] snd_exp_q[$];
    logic [7:0] mon_e;
    logic [7:0] mem [0:383];
    vec_t tbl [10];

    wts_ram_arbiter_if bus ();
    wts_ram_arbiter_if bus0 ();

    wts_ram_arbiter #(.RAM_DEPTH(384), .ROUND_ROBIN(1'b1)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    wts_ram_arbiter #(.RAM_DEPTH(384), .ROUND_ROBIN(1'b0)) dut0 (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sram_we && bus.sram_a < 9'd384) mem[bus.sram_a] <= bus.sram_d;
        bus.sram_q <= (bus.sram_a < 9'd384) ? mem[bus.sram_a] : 8'hAA;
    end

    always @(posedge clk) bus0.sram_q <= bus0.sram_a[7:0];

    always @(posedge clk) if (bus.sram_we) we_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each ack pops the value queued when its request was driven.
    always @(negedge clk) begin
        if (bus.cpu_ack) begin
            cpu_ack_cnt++;
            if (cpu_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_ack_unexpected: got ack expected none");
            end else begin
                mon_e = cpu_exp_q.pop_front();
                check("cpu_q", 32'(bus.cpu_q), 32'(mon_e));
            end
        end
        if (bus.snd_ack) begin
            if (snd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snd_ack_unexpected: got ack expected none");
            end else begin
                mon_e = snd_exp_q.pop_front();
                check("snd_q", 32'(bus.snd_q), 32'(mon_e));
            end
        end
    end

    function automatic vec_t mk_cpu(bit wr, logic [8:0] a, logic [7:0] d, logic [7:0] q);
        vec_t v;
        v.is_snd = 1'b0; v.wr = wr; v.a = a; v.ch = '0; v.idx = '0; v.d = d;
        v.exp_a = a; v.exp_we = wr && (a < 9'd384); v.exp_q = q;
        return v;
    endfunction

    function automatic vec_t mk_snd(logic [3:0] ch, logic [4:0] idx, logic [7:0] q);
        vec_t v;
        v.is_snd = 1'b1; v.wr = 1'b0; v.a = '0; v.ch = ch; v.idx = idx; v.d = '0;
        v.exp_a = 9'(ch * 32 + idx); v.exp_we = 1'b0; v.exp_q = q;
        return v;
    endfunction

    task automatic check_zero(input string name);
        check({name, "_sram_we"}, 32'(bus.sram_we), 0);
        check({name, "_sram_a"},  32'(bus.sram_a), 0);
        check({name, "_sram_d"},  32'(bus.sram_d), 0);
        check({name, "_cpu_ack"}, 32'(bus.cpu_ack), 0);
        check({name, "_cpu_q"},   32'(bus.cpu_q), 0);
        check({name, "_snd_ack"}, 32'(bus.snd_ack), 0);
        check({name, "_snd_q"},   32'(bus.snd_q), 0);
    endtask

    // Single access from an idle arbiter: ADDR contents, ack latency and write-enable count.
    task automatic do_access(input vec_t v, input string name);
        int lat;
        int we0;
        bit got;
        @(negedge clk);
        if (v.is_snd) begin
            bus.snd_ch = v.ch; bus.snd_idx = v.idx; bus.snd_req = 1'b1;
            snd_exp_q.push_back(v.exp_q);
        end else begin
            bus.cpu_wr = v.wr; bus.cpu_a = v.a; bus.cpu_d = v.d; bus.cpu_req = 1'b1;
            if (v.wr) begin
                cpu_exp_q.push_back(last_cpu_q);
            end else begin
                cpu_exp_q.push_back(v.exp_q);
                last_cpu_q = v.exp_q;
            end
        end
        we0 = we_cnt;
        @(posedge clk);
        @(negedge clk);
        check({name, "_addr_a"}, 32'(bus.sram_a), 32'(v.exp_a));
        check({name, "_addr_we"}, 32'(bus.sram_we), 32'(v.exp_we));
        if (v.exp_we) check({name, "_addr_d"}, 32'(bus.sram_d), 32'(v.d));
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 6) begin
            if (v.is_snd ? bus.snd_ack : bus.cpu_ack) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_ack_lat"}, got ? 32'(lat) : 32'd0, 3);
        bus.cpu_req = 1'b0;
        bus.snd_req = 1'b0;
        check({name, "_we_cycles"}, 32'(we_cnt - we0), 32'(v.exp_we));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int we0;
        int ack0;
        int k;
        int cyc;
        int n_c;
        int n_s;
        int s_acks;
        int c_acks;
        bit seq [4];

        nreset = 1'b0;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_a = 0; bus.cpu_d = 0;
        bus.snd_req = 0; bus.snd_ch = 0; bus.snd_idx = 0;
        bus0.cpu_req = 0; bus0.cpu_wr = 0; bus0.cpu_a = 0; bus0.cpu_d = 0;
        bus0.snd_req = 0; bus0.snd_ch = 0; bus0.snd_idx = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        nreset = 1'b1;

        we0 = we_cnt;
        for (int i = 0; i < 384; i++) do_access(mk_cpu(1'b1, 9'(i), 8'(i + 100), 8'h00), "fill");
        check("fill_we_total", 32'(we_cnt - we0), 384);
        for (int i = 0; i < 384; i++) do_access(mk_cpu(1'b0, 9'(i), 8'h00, 8'(i + 100)), "read");

        tbl[0] = mk_cpu(1'b1, 9'd400, 8'h33, 8'h00);
        tbl[1] = mk_cpu(1'b0, 9'd400, 8'h00, 8'hFF);
        tbl[2] = mk_snd(4'd5, 5'd7, 8'd11);
        tbl[3] = mk_snd(4'd13, 5'd0, 8'h00);
        tbl[4] = mk_snd(4'd11, 5'd31, 8'd227);
        tbl[5] = mk_cpu(1'b0, 9'd383, 8'h00, 8'd227);
        tbl[6] = mk_cpu(1'b1, 9'd10, 8'h5A, 8'h00);
        tbl[7] = mk_cpu(1'b0, 9'd10, 8'h00, 8'h5A);
        tbl[8] = mk_snd(4'd0, 5'd10, 8'h5A);
        tbl[9] = mk_snd(4'd12, 5'd0, 8'h00);
        for (int i = 0; i < 10; i++) do_access(tbl[i], $sformatf("vec%0d", i));

        // Reset during the ADDR cycle of a write.
        @(negedge clk);
        bus.cpu_wr = 1'b1; bus.cpu_a = 9'd20; bus.cpu_d = 8'hC3; bus.cpu_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_we_before", 32'(bus.sram_we), 1);
        #2 nreset = 1'b0;
        #1 check("rst_we_drop", 32'(bus.sram_we), 0);
        bus.cpu_req = 1'b0;
        ack0 = cpu_ack_cnt;
        last_cpu_q = 8'h00;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst_no_ack", 32'(cpu_ack_cnt - ack0), 0);
        check_zero("after_rst");

        // Tie held for four grants right after reset: sound first, then alternate.
        cpu_exp_q.push_back(8'd100); cpu_exp_q.push_back(8'd100);
        snd_exp_q.push_back(8'd11);  snd_exp_q.push_back(8'd11);
        last_cpu_q = 8'd100;
        @(negedge clk);
        bus.cpu_wr = 1'b0; bus.cpu_a = 9'd0; bus.cpu_req = 1'b1;
        bus.snd_ch = 4'd5; bus.snd_idx = 5'd7; bus.snd_req = 1'b1;
        k = 0; cyc = 0; n_c = 0; n_s = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.snd_ack && k < 4) begin
                seq[k] = 1'b1; k++; n_s++;
                if (n_s == 2) bus.snd_req = 1'b0;
            end
            if (bus.cpu_ack && k < 4) begin
                seq[k] = 1'b0; k++; n_c++;
                if (n_c == 2) bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        bus.snd_req = 1'b0;
        check("tie_grants", 32'(k), 4);
        for (int i = 0; i < 4; i++) check($sformatf("tie_order%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        repeat (3) @(negedge clk);

        // Strict priority instance: sound monopolises while held.
        @(negedge clk);
        bus0.cpu_wr = 1'b0; bus0.cpu_a = 9'd3; bus0.cpu_req = 1'b1;
        bus0.snd_ch = 4'd1; bus0.snd_idx = 5'd2; bus0.snd_req = 1'b1;
        s_acks = 0; c_acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus0.snd_ack) begin
                s_acks++;
                check("prio_snd_q", 32'(bus0.snd_q), 34);
            end
            if (bus0.cpu_ack) c_acks++;
        end
        bus0.cpu_req = 1'b0;
        bus0.snd_req = 1'b0;
        check("prio_cpu_acks", 32'(c_acks), 0);
        check("prio_snd_acks_ge3", 32'(s_acks >= 3), 1);
        repeat (3) @(negedge clk);

        check("queues_drained", 32'(cpu_exp_q.size() + snd_exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
